wb_trace_collector: RTL
=======================

WB_TRACE_COLLECTOR -- requirements
Module: wb_trace_collector

Interface
REQ-001 Parameter: DEPTH, 8, number of buffered writeback events; power of two, 2..64.
REQ-002 Parameter: DROP_W, 16, width of the dropped-event counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  capture enable; 0 ignores all writeback events.
REQ-006 Port: RegWrite_in  input  1  processor writeback strobe; one event per cycle when high.
REQ-007 Port: WriteData_in  input  32  writeback value qualified by RegWrite_in.
REQ-008 Port: PC_in  input  32  PC sampled alongside the event.
REQ-009 Port: trace_valid  output  1  stream word valid.
REQ-010 Port: trace_data  output  32  stream word.
REQ-011 Port: trace_last  output  1  high on the final word of each event.
REQ-012 Port: trace_ready  input  1  sink accepts word when high with trace_valid.
REQ-013 Port: fifo_count  output  $clog2(DEPTH)+1  buffered events, 0..DEPTH.
REQ-014 Port: overflow  output  1  sticky; set on the first dropped event.
REQ-015 Port: drop_count  output  DROP_W  dropped events, saturating at all-ones.

Function
REQ-016 Accept an event at an edge where enable && RegWrite_in && fifo_count<DEPTH; store {seq, PC_in[23:0], WriteData_in}.
REQ-017 When fifo_count==DEPTH, drop the event even if a pop occurs in the same cycle; set overflow; increment drop_count (saturating).
REQ-018 seq: 8-bit counter, incremented per accepted event only, wraps 255->0; first accepted event after reset carries seq 0.
REQ-019 Each event emits two words: header {seq[7:0], PC[23:0]} with trace_last=0, then data WriteData with trace_last=1.
REQ-020 Output FSM states: IDLE (valid=0), HDR (header word), DATA (data word).
REQ-021 IDLE->HDR when fifo_count>0; HDR->DATA on handshake; DATA->HDR on handshake if post-pop count (including same-cycle push) >0, else IDLE.
REQ-022 The FIFO entry is popped on the DATA handshake only.
REQ-023 While trace_valid=1 and trace_ready=0, trace_data, trace_last and state hold; trace_valid never deasserts without a handshake.
REQ-024 Latency: event accepted at edge N from an empty IDLE collector yields trace_valid=1 (header) after edge N+1.
REQ-025 Throughput: with trace_ready held high, one word per cycle, no bubble between back-to-back events.
REQ-026 fifo_count updates on each edge: +1 on push, -1 on pop, unchanged on both or neither.
REQ-027 All outputs are registered or decoded from registered state; no combinational path from trace_ready to trace_valid/trace_data.

Reset
REQ-028 On reset: FSM=IDLE; FIFO empty; seq=0; fifo_count=0; overflow=0; drop_count=0; trace_valid=0; trace_data=0; trace_last=0.
REQ-029 Reset mid-transfer abandons the current event; no partial event is resent; an event present on the reset edge is not captured.

Structure
REQ-030 A shared package holds the FSM state enum, SEQ_W=8, PC_FIELD_W=24 and the header field positions.
REQ-031 The storage is one sub-module, trace_fifo (synchronous, DEPTH entries of 64 bits, push/pop/count); the FSM and counters live in wb_trace_collector.

Verification
REQ-032 Single event PC=0x00000010, data=0x0000002A, ready=1 -> header 0x00000010 (last=0) then 0x0000002A (last=1); valid rises one cycle after the capture edge.
REQ-033 Ten back-to-back events, ready=0 until done, DEPTH=8 -> 8 buffered, drop_count=2, overflow=1; after ready=1, 16 words with seq 0..7.
REQ-034 Ready toggling 1/0 every cycle across 3 events -> words held stable while stalled; 6 words in order, no duplicates.
REQ-035 Simultaneous push and pop with fifo_count=3 -> fifo_count stays 3; DATA->HDR with no idle cycle.
REQ-036 300 accepted events -> seq wraps 255->0; drop_count saturates at 0xFFFF under forced overflow.
REQ-037 Reset asserted while in DATA with ready=0 -> next cycle valid=0, fifo_count=0, overflow=0; the next event carries seq 0.

Source files
------------

// File: rtl/wb_trace_collector_pkg.sv
// Shared types and field layout for the writeback trace collector.
// One buffered event is {seq, pc[23:0], data}; its header word is {seq, pc[23:0]}.
package wb_trace_collector_pkg;

  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned PC_FIELD_W  = 24;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ENTRY_W     = SEQ_W + PC_FIELD_W + DATA_W;
  localparam int unsigned HDR_PC_LSB  = 0;
  localparam int unsigned HDR_SEQ_LSB = PC_FIELD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
    logic [PC_FIELD_W-1:0] pc;
    logic [DATA_W-1:0]     data;
  } trace_entry_t;

  function automatic logic [DATA_W-1:0] make_header(input trace_entry_t e);
    logic [DATA_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_SEQ_LSB +: SEQ_W]     = e.seq;
    hdr[HDR_PC_LSB +: PC_FIELD_W] = e.pc;
    return hdr;
  endfunction

endpackage

// File: rtl/wb_trace_collector_fifo.sv
// Synchronous event store for the trace collector: DEPTH x 64-bit entries.
// Exposes the head and the entry behind it so the streamer can chain events without a bubble.
module trace_fifo
  import wb_trace_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ENTRY_W-1:0]     wr_data,
  output logic [ENTRY_W-1:0]     head,
  output logic [ENTRY_W-1:0]     head_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [CNT_W-1:0]   count_q, count_d;

  assign rd_ptr_nxt = PTR_W'(rd_ptr_q + 1'b1);

  // Caller guarantees push only when not full and pop only when not empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_nxt;
    end
    if (push && !pop) begin
      count_d = CNT_W'(count_q + 1'b1);
    end else if (pop && !push) begin
      count_d = CNT_W'(count_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_nxt];
  assign count     = count_q;

endmodule

// File: rtl/wb_trace_collector.sv
// Captures processor writeback events into a FIFO and streams each one out
// as a header word {seq, pc[23:0]} followed by a data word on a valid/ready port.
module wb_trace_collector
  import wb_trace_collector_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   RegWrite_in,
  input  logic [31:0]            WriteData_in,
  input  logic [31:0]            PC_in,
  output logic                   trace_valid,
  output logic [31:0]            trace_data,
  output logic                   trace_last,
  input  logic                   trace_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  trace_state_e      state_q, state_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0]  count_c;
  logic              event_c, full_c, push_c, drop_c, pop_c, hs_c;
  trace_entry_t      push_entry_c, head_c, head_next_c;
  logic              unused_pc_hi;

  assign event_c      = enable && RegWrite_in;
  assign full_c       = (count_c == CNT_W'(DEPTH));
  assign push_c       = event_c && !full_c;
  assign drop_c       = event_c && full_c;
  assign hs_c         = valid_q && trace_ready;
  assign push_entry_c = {seq_q, PC_in[PC_FIELD_W-1:0], WriteData_in};
  assign unused_pc_hi = ^PC_in[DATA_W-1:PC_FIELD_W];

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .wr_data   (push_entry_c),
    .head      (head_c),
    .head_next (head_next_c),
    .count     (count_c)
  );

  // Output streamer; the word for the next state is registered alongside the state.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    pop_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count_c != '0) begin
          state_d = ST_HDR;
          valid_d = 1'b1;
          data_d  = make_header(head_c);
          last_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (hs_c) begin
          state_d = ST_DATA;
          data_d  = head_c.data;
          last_d  = 1'b1;
        end
      end
      ST_DATA: begin
        if (hs_c) begin
          pop_c = 1'b1;
          // Next header comes from the entry behind the head, or from a same-cycle push.
          if (count_c > CNT_W'(1)) begin
            state_d = ST_HDR;
            data_d  = make_header(head_next_c);
            last_d  = 1'b0;
          end else if (push_c) begin
            state_d = ST_HDR;
            data_d  = make_header(push_entry_c);
            last_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Sequence number and drop bookkeeping.
  always_comb begin
    seq_d  = seq_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (push_c) begin
      seq_d = SEQ_W'(seq_q + 1'b1);
    end
    if (drop_c) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = DROP_W'(drop_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign trace_valid = valid_q;
  assign trace_data  = data_q;
  assign trace_last  = last_q;
  assign fifo_count  = count_c;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;

endmodule
